// File: rtl/riscv_crypto_aes_sbox_seq_pkg.sv
// -----------------------------------------------------------------------------
// riscv_crypto_pkg
// Shared definitions for the AES S-box sequencer and its helpers.
//   seq_state_t       : sequencer state encoding (IDLE / RUN / DONE)
//   AES_SBOX_REQ_RND  : requester id of the round datapath
//   AES_SBOX_REQ_KS   : requester id of the key-schedule unit
//   seq_cnt_width()   : width of the per-request byte counter
// -----------------------------------------------------------------------------
package riscv_crypto_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

    localparam logic AES_SBOX_REQ_RND = 1'b0;
    localparam logic AES_SBOX_REQ_KS  = 1'b1;

    // One bit more than needed to index NBYTES bytes, so the counter can
    // also hold NBYTES itself when the S-box output is pipelined.
    function automatic int seq_cnt_width(input int nbytes);
        return $clog2(nbytes) + 1;
    endfunction

endpackage

// File: rtl/riscv_crypto_aes_sbox_seq_if.sv
// -----------------------------------------------------------------------------
// riscv_crypto_aes_sbox_seq_if
// Request/response bundle of the shared S-box sequencer.
//   master modport : requesters + response consumer (drive req_*, rsp_ready,
//                    flush; observe req_ready, rsp_*, busy, dbg_state)
//   slave modport  : the sequencer
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A requester holds data/dec stable while valid is high and
// ready is low; it may drop valid before a transfer (request not served).
// The sequencer holds rsp_id/rsp_data stable while rsp_valid is high and
// rsp_ready is low.
// -----------------------------------------------------------------------------
interface riscv_crypto_aes_sbox_seq_if
    import riscv_crypto_pkg::*;
#(
    parameter int NBYTES = 4
);
    logic                  flush;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic                  req_dec0;
    logic [8*NBYTES-1:0]   req_data0;
    logic                  req_dec1;
    logic [8*NBYTES-1:0]   req_data1;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [8*NBYTES-1:0]   rsp_data;
    logic                  busy;
    seq_state_t            dbg_state;

    modport master (
        output flush, req_valid, req_dec0, req_data0, req_dec1, req_data1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy, dbg_state
    );

    modport slave (
        input  flush, req_valid, req_dec0, req_data0, req_dec1, req_data1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy, dbg_state
    );
endinterface

// File: rtl/riscv_crypto_aes_sbox.sv
// -----------------------------------------------------------------------------
// riscv_crypto_aes_sbox
// Combinational AES S-box, forward and inverse.
//   dec_i : 1 = inverse S-box, 0 = forward S-box
//   in_i  : input byte
//   out_o : substituted byte
// Built from the GF(2^8) multiplicative inverse (x^254) and the AES affine
// transform rather than lookup tables.
// -----------------------------------------------------------------------------
module riscv_crypto_aes_sbox (
    input  logic       dec_i,
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    logic [7:0] fwd_out;
    logic [7:0] inv_aff;
    logic [7:0] inv_out;

    assign fwd_out = gf_inv(in_i) ^ rotl(gf_inv(in_i), 1) ^ rotl(gf_inv(in_i), 2)
                   ^ rotl(gf_inv(in_i), 3) ^ rotl(gf_inv(in_i), 4) ^ 8'h63;
    assign inv_aff = rotl(in_i, 1) ^ rotl(in_i, 3) ^ rotl(in_i, 6) ^ 8'h05;
    assign inv_out = gf_inv(inv_aff);
    assign out_o   = dec_i ? inv_out : fwd_out;

endmodule

// File: rtl/riscv_crypto_aes_sbox_seq_arb.sv
// -----------------------------------------------------------------------------
// riscv_crypto_rr_arb2
// Two-way round-robin arbiter for shared functional-unit resources.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i[1:0]    : request bits
//   en_i          : grants allowed this cycle
//   accept_i      : the granted request is taken at this edge
//   gnt_o[1:0]    : one-hot grant (zero when disabled or no request)
//   gnt_id_o      : index of the requester that would be granted
// The pointer names the favoured requester on a tie; after an accept it
// moves to the other requester. Reset favours requester 0.
// -----------------------------------------------------------------------------
module riscv_crypto_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    logic ptr_q;

    always_comb begin
        gnt_id_o = ptr_q;
        if (req_i == 2'b01)      gnt_id_o = 1'b0;
        else if (req_i == 2'b10) gnt_id_o = 1'b1;
        gnt_o = 2'b00;
        if (en_i && req_i[gnt_id_o]) gnt_o = gnt_id_o ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else if (accept_i) begin
            ptr_q <= ~gnt_id_o;
        end
    end

endmodule

// File: rtl/riscv_crypto_aes_sbox_seq.sv
// -----------------------------------------------------------------------------
// riscv_crypto_aes_sbox_seq
// Shares one AES S-box between the round datapath (id 0) and the key
// schedule (id 1). An accepted word is pushed through the S-box one byte per
// cycle, LSB byte first, and returned on a valid/ready response channel.
//   g_clk, g_resetn : clock, asynchronous active-low reset
//   bus (slave)     : flush, req_valid/req_ready, req_dec0/1, req_data0/1,
//                     rsp_valid/rsp_ready, rsp_id, rsp_data, busy, dbg_state
// Parameter NBYTES (1..8) must match the interface instance.
// Optional macro RISCV_CRYPTO_SBOX_SEQ_REG_EN: registers the S-box output,
// adding one cycle of latency (NBYTES+1 instead of NBYTES).
// -----------------------------------------------------------------------------
module riscv_crypto_aes_sbox_seq
    import riscv_crypto_pkg::*;
#(
    parameter int NBYTES = 4
)
(
    input  logic                             g_clk,
    input  logic                             g_resetn,
    riscv_crypto_aes_sbox_seq_if.slave       bus
);

    localparam int            W        = 8 * NBYTES;
    localparam int            CW       = seq_cnt_width(NBYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    seq_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  data_q;
    logic [W-1:0]  result_q;
    logic          dec_q;
    logic          id_q;
    logic          rsp_valid_q;
    logic          busy_q;
    logic          rst_done_q;   // keeps req_ready low while in reset

    logic          grant_en;
    logic [1:0]    gnt;
    logic          gnt_id;
    logic          accept;
    logic [W-1:0]  data_d;
    logic          dec_d;
    logic [7:0]    sbox_in;
    logic [7:0]    sbox_out;

`ifdef RISCV_CRYPTO_SBOX_SEQ_REG_EN
    localparam logic [CW-1:0] NB_C = CW'(NBYTES);
    logic [7:0]    pipe_q;
    logic [CW-1:0] pipe_idx_q;
    logic          pipe_vld_q;
`endif

    assign grant_en = rst_done_q && (state_q == SEQ_IDLE) && !bus.flush;

    riscv_crypto_rr_arb2 u_arb (
        .clk_i    (g_clk),
        .rst_ni   (g_resetn),
        .req_i    (bus.req_valid),
        .en_i     (grant_en),
        .accept_i (accept),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    // gnt is already qualified by req_valid, so any grant bit is a handshake.
    assign accept = |gnt;
    assign data_d = (gnt_id == AES_SBOX_REQ_KS) ? bus.req_data1 : bus.req_data0;
    assign dec_d  = (gnt_id == AES_SBOX_REQ_KS) ? bus.req_dec1  : bus.req_dec0;

    always_comb begin
        sbox_in = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (cnt_q == CW'(b)) sbox_in = data_q[8*b +: 8];
        end
    end

    riscv_crypto_aes_sbox u_sbox (
        .dec_i (dec_q),
        .in_i  (sbox_in),
        .out_o (sbox_out)
    );

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q     <= SEQ_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            result_q    <= '0;
            dec_q       <= 1'b0;
            id_q        <= AES_SBOX_REQ_RND;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rst_done_q  <= 1'b0;
`ifdef RISCV_CRYPTO_SBOX_SEQ_REG_EN
            pipe_q      <= 8'h00;
            pipe_idx_q  <= '0;
            pipe_vld_q  <= 1'b0;
`endif
        end else begin
            rst_done_q <= 1'b1;
            case (state_q)
                SEQ_IDLE: begin
                    if (accept) begin
                        data_q  <= data_d;
                        dec_q   <= dec_d;
                        id_q    <= gnt_id;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SEQ_RUN;
                    end
                end
                SEQ_RUN: begin
                    if (bus.flush) begin
                        busy_q  <= 1'b0;
                        state_q <= SEQ_IDLE;
`ifdef RISCV_CRYPTO_SBOX_SEQ_REG_EN
                        pipe_vld_q <= 1'b0;
`endif
                    end else begin
`ifdef RISCV_CRYPTO_SBOX_SEQ_REG_EN
                        // Issue stage: byte cnt_q enters the pipeline register.
                        if (cnt_q < NB_C) begin
                            pipe_q     <= sbox_out;
                            pipe_idx_q <= cnt_q;
                            pipe_vld_q <= 1'b1;
                            cnt_q      <= cnt_q + 1'b1;
                        end else begin
                            pipe_vld_q <= 1'b0;
                        end
                        // Write stage: the byte issued last cycle lands in result.
                        if (pipe_vld_q) begin
                            for (int b = 0; b < NBYTES; b++) begin
                                if (pipe_idx_q == CW'(b)) result_q[8*b +: 8] <= pipe_q;
                            end
                            if (pipe_idx_q == LAST_IDX) begin
                                rsp_valid_q <= 1'b1;
                                state_q     <= SEQ_DONE;
                            end
                        end
`else
                        for (int b = 0; b < NBYTES; b++) begin
                            if (cnt_q == CW'(b)) result_q[8*b +: 8] <= sbox_out;
                        end
                        if (cnt_q == LAST_IDX) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= SEQ_DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`endif
                    end
                end
                SEQ_DONE: begin
                    // A flush drops the response even if it is being taken.
                    if (bus.flush || bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= SEQ_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= SEQ_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = result_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_riscv_crypto_aes_sbox_seq.sv
// -----------------------------------------------------------------------------
// tb_riscv_crypto_aes_sbox_seq
// Self-checking bench for the shared AES S-box sequencer. Expected words come
// from S-box tables generated in the bench from the AES field definitions.
// Define RISCV_CRYPTO_SBOX_SEQ_REG_EN for both RTL and bench to exercise the
// pipelined S-box output.
// -----------------------------------------------------------------------------
module tb_riscv_crypto_aes_sbox_seq;
    import riscv_crypto_pkg::*;

    localparam int NB = 4;
    localparam int W  = 8 * NB;
`ifdef RISCV_CRYPTO_SBOX_SEQ_REG_EN
    localparam int LAT = NB + 1;
`else
    localparam int LAT = NB;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    riscv_crypto_aes_sbox_seq_if #(.NBYTES(NB)) bus ();

    riscv_crypto_aes_sbox_seq #(.NBYTES(NB)) dut (
        .g_clk    (clk),
        .g_resetn (rst_n),
        .bus      (bus)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic         exp_id_q[$];

    logic [7:0] fwd_t [0:255];
    logic [7:0] inv_t [0:255];

    typedef struct {
        int         id;
        logic       dec;
        logic [W-1:0] data;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    // Walks the generator 3 and its inverse in lockstep, so q = p^-1 at
    // every step; then applies the affine transform.
    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            fwd_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fwd_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);
    endtask

    function automatic logic [W-1:0] model(input logic dec, input logic [W-1:0] data);
        logic [W-1:0] r;
        r = '0;
        for (int b = 0; b < NB; b++)
            r[8*b +: 8] = dec ? inv_t[data[8*b +: 8]] : fwd_t[data[8*b +: 8]];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_req(input int id, input logic dec, input logic [W-1:0] data);
        int g;
        @(negedge clk);
        if (id == 0) begin
            bus.req_dec0  = dec;
            bus.req_data0 = data;
        end else begin
            bus.req_dec1  = dec;
            bus.req_data1 = data;
        end
        bus.req_valid[id] = 1'b1;
        #1;
        g = 0;
        while (!bus.req_ready[id] && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (!bus.req_ready[id]) fail_now("req_ready_wait");
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_any_ready();
        int g;
        @(negedge clk);
        #1;
        g = 0;
        while (bus.req_ready == 2'b00 && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (bus.req_ready == 2'b00) fail_now("any_ready_wait");
    endtask

    // Called right after the request handshake edge; counts edges to rsp_valid.
    task automatic get_rsp(input int exp_lat);
        int lat;
        logic [W-1:0] e;
        logic eid;
        lat = 0;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        if (!bus.rsp_valid) begin
            fail_now("rsp_valid_wait");
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                eid = exp_id_q.pop_front();
            end
            return;
        end
        if (exp_lat >= 0) check("latency", 64'(lat), 64'(exp_lat));
        if (exp_q.size() == 0) begin
            fail_now("scoreboard_empty");
            return;
        end
        e   = exp_q.pop_front();
        eid = exp_id_q.pop_front();
        check("rsp_data", 64'(bus.rsp_data), 64'(e));
        check("rsp_id", 64'(bus.rsp_id), 64'(eid));
        if (bus.rsp_ready) begin
            @(posedge clk);
            #1;
            check("idle_after_rsp", 64'(bus.busy), 64'd0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int exp_ptr;
        int id;
        logic dec;
        logic [W-1:0] d;
        logic bad;

        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_dec0  = 1'b0;
        bus.req_data0 = '0;
        bus.req_dec1  = 1'b0;
        bus.req_data1 = '0;
        bus.rsp_ready = 1'b1;
        build_tables();

        vecs[0] = '{0, 1'b0, 32'h53020100, 32'hED777C63};
        vecs[1] = '{1, 1'b1, 32'hED777C63, 32'h53020100};
        vecs[2] = '{0, 1'b0, 32'h00000000, 32'h63636363};
        vecs[3] = '{1, 1'b0, 32'hFFFFFFFF, 32'h16161616};
        vecs[4] = '{0, 1'b1, 32'h63636363, 32'h00000000};
        vecs[5] = '{1, 1'b1, 32'h16161616, 32'hFFFFFFFF};

        // Reset state, with both requesters already asking.
        bus.req_data0 = 32'h53020100;
        bus.req_dec0  = 1'b0;
        bus.req_data1 = 32'hED777C63;
        bus.req_dec1  = 1'b1;
        bus.req_valid = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_state", 64'(bus.dbg_state), 64'(SEQ_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // Arbitration: both held valid, grants alternate starting with 0.
        exp_ptr = 0;
        for (int t = 0; t < 4; t++) begin
            wait_any_ready();
            check("arb_grant", 64'(bus.req_ready), (exp_ptr == 0) ? 64'd1 : 64'd2);
            exp_q.push_back((exp_ptr == 0) ? 32'hED777C63 : 32'h53020100);
            exp_id_q.push_back(exp_ptr[0]);
            @(posedge clk);
            #1;
            if (t == 3) bus.req_valid = 2'b00;
            check("run_ready_low", 64'(bus.req_ready), 64'd0);
            exp_ptr ^= 1;
            get_rsp(LAT);
        end

        // Table-driven vectors.
        for (int i = 0; i < 6; i++) begin
            send_req(vecs[i].id, vecs[i].dec, vecs[i].data);
            exp_q.push_back(vecs[i].exp);
            exp_id_q.push_back(vecs[i].id[0]);
            get_rsp(LAT);
        end

        // Back-pressure: 10 cycles in DONE, other requester waiting.
        bus.rsp_ready = 1'b0;
        send_req(0, 1'b0, 32'h53020100);
        exp_q.push_back(32'hED777C63);
        exp_id_q.push_back(1'b0);
        get_rsp(LAT);
        bus.req_data1 = '0;
        bus.req_dec1  = 1'b0;
        bus.req_valid = 2'b10;
        bad = 1'b0;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            #1;
            if (!bus.rsp_valid || bus.rsp_data !== 32'hED777C63 || bus.rsp_id !== 1'b0
                || bus.req_ready !== 2'b00) bad = 1'b1;
        end
        check("bp_stable", 64'(bad), 64'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 64'(bus.rsp_valid), 64'd0);
        check("bp_release_state", 64'(bus.dbg_state), 64'(SEQ_IDLE));
        check("bp_idle_ready", 64'(bus.req_ready), 64'd2);
        bus.req_valid = 2'b00;

        // Flush in RUN cycle 2: response dropped.
        send_req(0, 1'b0, 32'hFFFFFFFF);
        repeat (3) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush_run_busy", 64'(bus.busy), 64'd0);
        bad = 1'b0;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            if (bus.rsp_valid) bad = 1'b1;
        end
        check("flush_run_no_rsp", 64'(bad), 64'd0);
        send_req(0, 1'b0, 32'h00000000);
        exp_q.push_back(32'h63636363);
        exp_id_q.push_back(1'b0);
        get_rsp(LAT);

        // Flush in IDLE suppresses req_ready.
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.flush     = 1'b1;
        #1;
        check("flush_idle_ready", 64'(bus.req_ready), 64'd0);
        bus.flush = 1'b0;
        #1;
        check("noflush_idle_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 2'b00;

        // Flush in DONE drops a stalled response.
        bus.rsp_ready = 1'b0;
        send_req(1, 1'b0, 32'h00000000);
        exp_q.push_back(32'h63636363);
        exp_id_q.push_back(1'b1);
        get_rsp(LAT);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush_done_valid", 64'(bus.rsp_valid), 64'd0);
        check("flush_done_busy", 64'(bus.busy), 64'd0);
        bus.rsp_ready = 1'b1;

        // Async reset mid-RUN after a requester-0 grant (pointer moved to 1).
        send_req(0, 1'b0, 32'h53020100);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("arst_rsp_data", 64'(bus.rsp_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_data0 = 32'h53020100;
        bus.req_dec0  = 1'b0;
        bus.req_data1 = 32'hED777C63;
        bus.req_dec1  = 1'b1;
        bus.req_valid = 2'b11;
        wait_any_ready();
        check("arst_ptr_grant", 64'(bus.req_ready), 64'd1);
        exp_q.push_back(32'hED777C63);
        exp_id_q.push_back(1'b0);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        get_rsp(LAT);

        // Randomized requests against the model.
        for (int i = 0; i < 30; i++) begin
            id  = $urandom_range(0, 1);
            dec = 1'($urandom_range(0, 1));
            d   = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_req(id, dec, d);
            exp_q.push_back(model(dec, d));
            exp_id_q.push_back(id[0]);
            get_rsp(LAT);
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_crypto_aes_sbox_seq.md
Name: riscv_crypto_aes_sbox_seq

Overview:
- Sequencer/arbiter sharing one combinational forward/inverse AES S-box instance (riscv_crypto_aes_sbox) between two requesters: the round datapath (id 0) and the key-schedule unit (id 1).
- Each request carries an NBYTES-wide word and a direction flag. The block pushes one byte per cycle through the single S-box, assembles the result, and returns it on a valid/ready response channel tagged with the requester id.
- Trades latency for area in the crypto FU: one S-box instead of 2×NBYTES.

Parameters:
- NBYTES, 4, bytes per request (legal 1..8); word width W = 8*NBYTES.

Ports:
- g_clk  input  1  clock, all state on rising edge.
- g_resetn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of the in-flight operation.
- req_valid  input  2  per-requester request valid; bit i = requester i.
- req_ready  output  2  per-requester accept; at most one bit high.
- req_dec0  input  1  requester 0 direction: 1 = inverse S-box, 0 = forward.
- req_data0  input  W  requester 0 word.
- req_dec1  input  1  requester 1 direction.
- req_data1  input  W  requester 1 word.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accept.
- rsp_id  output  1  id of the requester that owns rsp_data.
- rsp_data  output  W  S-box applied bytewise to the accepted word.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (g_resetn=0, async):
  - state=IDLE; rr pointer=0 (requester 0 favoured first); byte counter=0.
  - Result register=0; rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0, busy=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - Grant is combinational. If one req_valid bit is set, that requester is granted.
  - If both are set, the requester selected by the rr pointer is granted.
  - req_ready[grant]=1 only in IDLE and only while its req_valid=1.
  - On handshake:
    - latch data, dec and id;
    - set rr pointer to the other requester;
    - clear the counter;
    - go to RUN.
- RUN:
  - Cycle i (i=0..NBYTES-1) feeds latched byte i (bits 8i+7:8i, LSB byte first) and the latched dec into the S-box.
  - The S-box output is written into result byte i at the same edge.
  - After byte NBYTES-1 is written, go to DONE.
  - Latency: handshake edge k → rsp_valid high after edge k+NBYTES.
- DONE:
  - rsp_valid=1; rsp_data and rsp_id are held stable until rsp_valid && rsp_ready, then go to IDLE.
  - No new request is accepted in the handshake cycle, so the minimum initiation interval is NBYTES+2 cycles.
  - Back-pressure has unlimited duration with no data change.
- flush:
  - In RUN or DONE: go to IDLE next edge, drop the response, rsp_valid=0 next cycle; the rr pointer is kept.
  - In IDLE: flush suppresses req_ready that cycle.
- Requesters must hold data and dec stable while valid and not ready. A request withdrawn before its handshake is legal and simply not served.
- The counter is log2(NBYTES)+1 bits wide; it cannot overrun because RUN exits exactly at NBYTES-1.
- An async reset mid-operation aborts with no response; outputs return to reset values immediately.

Optional Feature:
- Macro: RISCV_CRYPTO_SBOX_SEQ_REG_EN.
- Defined:
  - A pipeline register sits on the S-box output and relaxes timing.
  - Byte i is issued in RUN cycle i and written to the result one cycle later, so RUN lasts NBYTES+1 cycles.
  - Latency is NBYTES+1; flush also clears the pipeline register's valid bit.
- Undefined: behaviour exactly as above (latency NBYTES).

Decomposition:
- Shared package riscv_crypto_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - requester id constants (AES_SBOX_REQ_RND=1'b0, AES_SBOX_REQ_KS=1'b1).
- Sub-module riscv_crypto_rr_arb2: 2-way round-robin grant with pointer update on accept, reusable by other shared FU resources.
- The S-box is instantiated, not modified.

Test Plan:
- Forward: requester 0 sends data0=0x53020100, dec0=0 → rsp_valid after 4 cycles, rsp_data=0xED777C63, rsp_id=0.
- Inverse: requester 1 sends data1=0xED777C63, dec1=1 → rsp_data=0x53020100, rsp_id=1.
- Arbitration after reset: both valid at reset release → requester 0 served first, then requester 1; repeat with both still valid → requester 0 then 1 again (alternation).
- Back-pressure: hold rsp_ready=0 for 10 cycles in DONE → rsp_data=0xED777C63 stable, req_ready=0 throughout; rsp_ready=1 → IDLE next edge.
- Flush: flush at RUN cycle 2 of a forward request with data 0xFFFFFFFF → no rsp_valid; next request 0x00000000 → rsp_data=0x63636363.
- Reset mid-RUN: drive g_resetn low asynchronously → busy=0 and rsp_valid=0 immediately; after release the rr pointer is 0. With REG_EN defined, the forward test responds after 5 cycles.
